// File: rtl/load_store_unit.sv
// Multicycle RV64 load/store stage: doubleword memory access with a req/ready handshake,
// right-aligned load data in mdr and read-modify-write for sub-doubleword stores.
// Optional build macro MISALIGN_TRAP_EN: reject misaligned accesses with a misalign pulse.
module load_store_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       instrucao,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] mdr,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MERGE,
        WR,
        DONE
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t state, state_next;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_load_in;
    logic              is_store_in;
    logic              is_sd_in;
    logic              trap_in;
    logic              unused_instr;

    logic              op_load;
    logic [1:0]        size_q;
    logic [2:0]        off_q;
    logic [DATA_W-1:0] sdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] merged;
    logic [3:0]        nbytes;
    logic [2:0]        lane;

    assign opcode       = instrucao[6:0];
    assign funct3       = instrucao[14:12];
    assign unused_instr = ^{instrucao[31:15], instrucao[11:7]};

    // funct3 111 has no load and funct3[2]=1 has no store; those fall through as non-accesses
    assign is_load_in  = (opcode == OP_LOAD) && (funct3 != 3'b111);
    assign is_store_in = (opcode == OP_STORE) && !funct3[2];
    assign is_sd_in    = is_store_in && (funct3[1:0] == 2'b11);

`ifdef MISALIGN_TRAP_EN
    logic [2:0] align_mask;
    logic       misalign_q;

    always_comb begin
        align_mask = 3'b000;
        case (funct3[1:0])
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    end

    assign trap_in = (is_load_in || is_store_in) && ((addr[2:0] & align_mask) != 3'b000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (state == IDLE && start) begin
            misalign_q <= trap_in;
        end
    end

    assign misalign = (state == DONE) && misalign_q;
`else
    assign trap_in  = 1'b0;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory strobes decode straight from state so a reset drops mem_req without waiting for a clock
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (trap_in) begin
                        state_next = DONE;
                    end else if (is_load_in) begin
                        state_next = RD;
                    end else if (is_sd_in) begin
                        state_next = WR;
                    end else if (is_store_in) begin
                        state_next = RD;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            RD: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_next = op_load ? DONE : MERGE;
                end
            end
            MERGE: begin
                state_next = WR;
            end
            WR: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                if (mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Lanes past byte 7 never match, so oversize stores are clipped to the doubleword
    always_comb begin
        merged = rdata_q;
        nbytes = 4'd1 << size_q;
        lane   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            lane = 3'(i) - off_q;
            if ((4'(i) >= {1'b0, off_q}) && ({1'b0, lane} < nbytes)) begin
                merged[8*i +: 8] = sdata_q[8*lane +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdr       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            op_load   <= 1'b0;
            size_q    <= 2'b00;
            off_q     <= 3'b000;
            sdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_load <= is_load_in;
                        size_q  <= funct3[1:0];
                        off_q   <= addr[2:0];
                        sdata_q <= store_data;
                        if (!trap_in && (is_load_in || is_store_in)) begin
                            mem_addr <= {addr[ADDR_W-1:3], 3'b000};
                        end
                        if (!trap_in && is_sd_in) begin
                            mem_wdata <= store_data;
                        end
                    end
                end
                RD: begin
                    if (mem_ready) begin
                        if (op_load) begin
                            mdr <= mem_rdata >> {off_q, 3'b000};
                        end else begin
                            rdata_q <= mem_rdata;
                        end
                    end
                end
                MERGE: begin
                    mem_wdata <= merged;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
